fdc_sd_arbiter: RTL

- Downstream neighbour of the floppy controller. It collapses the four per-drive SD block request channels (sd_rd/sd_wr/sd_lba/sd_ack/sd_buff_din) onto one MiSTer block-device channel, freeing the other host virtual-disk slots.
- Grants one drive at a time using round-robin.
- Latches that drive's LBA and operation, and drives the host handshake.
- Routes sd_ack and write-buffer data back to the granted drive only.

---
 rtl/fdc_sd_arbiter.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/fdc_sd_arbiter.sv
// fdc_sd_arbiter: collapses the per-drive SD block request channels of the floppy
// controller onto a single host block-device channel. One drive is granted at a time,
// picked round-robin. Its LBA and operation are latched at grant, and the host ack and
// write data are routed to the granted drive only.
// Optional watchdog: define FDC_SD_ARB_TIMEOUT_EN to abort stalled REQ/XFER phases after
// TIMEOUT_CYCLES and raise a sticky timeout_err. Without it, timeout_err is tied 0.

module fdc_sd_arbiter #(
    parameter int unsigned N_DRV          = 4,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd16777215
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [3:0]       drv_rd,
    input  logic [3:0]       drv_wr,
    input  logic [3:0][31:0] drv_lba,
    input  logic [3:0][7:0]  drv_buff_din,
    output logic [3:0]       drv_ack,
    output logic [31:0]      sd_lba,
    output logic             sd_rd,
    output logic             sd_wr,
    input  logic             sd_ack,
    output logic [7:0]       sd_buff_din,
    output logic             busy,
    output logic [1:0]       grant_idx,
    output logic             timeout_err
);

    typedef enum logic [1:0] {StIdle, StReq, StXfer, StRelease} state_e;

    state_e      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  sel_q, sel_d;
    logic [31:0] lba_q, lba_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [3:0]  ack_q, ack_d;

    logic [3:0]  pending;
    logic        any_pending;
    logic [1:0]  rr_idx;
    logic [1:0]  cand;

`ifdef FDC_SD_ARB_TIMEOUT_EN
    logic [23:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        to_hit;

    assign to_hit = (cnt_q == TIMEOUT_CYCLES);
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    // Channels at or above N_DRV never request.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            pending[i] = (i < N_DRV) && (drv_rd[i] || drv_wr[i]);
        end
    end

    // Round-robin pick: scan from the highest offset down so the lowest offset wins.
    always_comb begin
        rr_idx      = ptr_q;
        any_pending = 1'b0;
        cand        = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_q + 2'(k);
            if (pending[cand]) begin
                rr_idx      = cand;
                any_pending = 1'b1;
            end
        end
    end

    // Next-state logic for the grant FSM and its registered outputs.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        lba_d   = lba_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        ack_d   = ack_q;
`ifdef FDC_SD_ARB_TIMEOUT_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (any_pending) begin
                    sel_d   = rr_idx;
                    lba_d   = drv_lba[rr_idx];
                    // Write wins when a drive raises both levels.
                    wr_d    = drv_wr[rr_idx];
                    rd_d    = drv_rd[rr_idx] & ~drv_wr[rr_idx];
                    ptr_d   = rr_idx + 2'd1;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (sd_ack) begin
                    rd_d         = 1'b0;
                    wr_d         = 1'b0;
                    ack_d        = 4'b0000;
                    ack_d[sel_q] = 1'b1;
                    state_d      = StXfer;
                end else if (!pending[sel_q]) begin
                    // Drive withdrew its command before the host answered.
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = StIdle;
                end
            end
            StXfer: begin
                if (!sd_ack) begin
                    ack_d   = 4'b0000;
                    state_d = StRelease;
                end
            end
            StRelease: begin
                // Hold off until the drive drops its level so it is not re-granted stale.
                if (!pending[sel_q]) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
`ifdef FDC_SD_ARB_TIMEOUT_EN
        if ((state_q == StReq || state_q == StXfer) && to_hit) begin
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            ack_d   = 4'b0000;
            err_d   = 1'b1;
            state_d = StRelease;
        end
`endif
    end

    // FSM state and registered outputs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= StIdle;
            ptr_q   <= 2'd0;
            sel_q   <= 2'd0;
            lba_q   <= 32'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ack_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            lba_q   <= lba_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ack_q   <= ack_d;
        end
    end

`ifdef FDC_SD_ARB_TIMEOUT_EN
    // Watchdog count: restarts on every state change, runs while waiting on the host.
    always_comb begin
        if (state_d != state_q) begin
            cnt_d = 24'd0;
        end else if (state_q == StReq || state_q == StXfer) begin
            cnt_d = cnt_q + 24'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Watchdog counter and sticky error flag.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q <= 24'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign timeout_err = err_q;
`else
    assign timeout_err = 1'b0;
`endif

    // Write data path: only the granted drive's buffer reaches the host.
    always_comb begin
        sd_buff_din = 8'h00;
        if (state_q == StReq || state_q == StXfer) begin
            sd_buff_din = drv_buff_din[sel_q];
        end
    end

    assign drv_ack   = ack_q;
    assign sd_lba    = lba_q;
    assign sd_rd     = rd_q;
    assign sd_wr     = wr_q;
    assign busy      = (state_q != StIdle);
    assign grant_idx = sel_q;

endmodule
